// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath mux selects and ALU class codes (also used by the ALU control decoder).
package control_unit_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       lord;
    logic       memory_read;
    logic       memory_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       is_immediate;
  } ctrl_t;

  // Moore decode: every control not named for a state stays 0.
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.memory_read = 1'b1;
        c.ir_write    = 1'b1;
        c.alu_src_a   = SRC_A_PC;
        c.alu_src_b   = SRC_B_FOUR;
        c.aluop       = ALUOP_ADD;
        c.pc_write    = 1'b1;
      end
      ST_DECODE: begin
        c.alu_src_a = SRC_A_OLDPC;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_MEMADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_MEMREAD: begin
        c.memory_read = 1'b1;
        c.lord        = 1'b1;
      end
      ST_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_MDR;
      end
      ST_MEMWRITE: begin
        c.memory_write = 1'b1;
        c.lord         = 1'b1;
      end
      ST_EXECR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.aluop     = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        c.alu_src_a    = SRC_A_RS1;
        c.alu_src_b    = SRC_B_IMM;
        c.aluop        = ALUOP_FUNCT;
        c.is_immediate = 1'b1;
      end
      ST_LUI: begin
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
      end
      ST_ALUWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_ALUOUT;
      end
      ST_BRANCH: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_RS2;
        c.aluop         = ALUOP_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      ST_JAL: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_PC;
        c.pc_write   = 1'b1;
        c.pc_source  = 1'b1;
      end
      ST_JALR: begin
        c.alu_src_a  = SRC_A_RS1;
        c.alu_src_b  = SRC_B_IMM;
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_PC;
        c.pc_write   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle RV32I main control FSM; 2-5 cycles per instruction, Moore outputs.
// No stall/backpressure: the datapath and memory always complete in one cycle.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] instruction_opcode_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       pc_source_o,
  output logic       lorD_o,
  output logic       memory_read_o,
  output logic       memory_write_o,
  output logic       ir_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] aluop_o,
  output logic       is_immediate_o,
  output logic [3:0] state_o
);

  state_t state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          case (instruction_opcode_i)
            OP_LOAD, OP_STORE: state <= ST_MEMADR;
            OP_REG:            state <= ST_EXECR;
            OP_IMM:            state <= ST_EXECI;
            OP_BRANCH:         state <= ST_BRANCH;
            OP_JAL:            state <= ST_JAL;
            OP_JALR:           state <= ST_JALR;
            OP_LUI:            state <= ST_LUI;
            OP_AUIPC:          state <= ST_ALUWB;  // PC-relative sum already in ALUOut
            default:           state <= ST_FETCH;
          endcase
        end
        ST_MEMADR:   state <= (instruction_opcode_i == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
        ST_MEMREAD:  state <= ST_MEMWB;
        ST_EXECR:    state <= ST_ALUWB;
        ST_EXECI:    state <= ST_ALUWB;
        ST_LUI:      state <= ST_ALUWB;
        default:     state <= ST_FETCH;
      endcase
    end
  end

  // Reset masks the decode immediately so no strobe leaks from a half-done instruction.
  always_comb begin
    ctrl = ctrl_decode(state);
    if (rst) ctrl = '0;
  end

  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign pc_source_o     = ctrl.pc_source;
  assign lorD_o          = ctrl.lord;
  assign memory_read_o   = ctrl.memory_read;
  assign memory_write_o  = ctrl.memory_write;
  assign ir_write_o      = ctrl.ir_write;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign aluop_o         = ctrl.aluop;
  assign is_immediate_o  = ctrl.is_immediate;
  assign state_o         = rst ? 4'd0 : state;

endmodule
